// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one byte-strobed write port, two registered read ports, per-entry written flags.
// Define REG_FILE_WR_BYPASS_EN to make same-cycle reads observe the in-flight write or clear.
module reg_file_2r1w #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Clr,
  input  logic                 WrEn,
  input  logic [ADDR_W-1:0]    WrAddr,
  input  logic [WIDTH/8-1:0]   WrStrb,
  input  logic [WIDTH-1:0]     WrData,
  input  logic                 RdEn0,
  input  logic [ADDR_W-1:0]    RdAddr0,
  input  logic                 RdEn1,
  input  logic [ADDR_W-1:0]    RdAddr1,
  output logic [WIDTH-1:0]     RdData0,
  output logic [WIDTH-1:0]     RdData1,
  output logic                 RdValid0,
  output logic                 RdValid1,
  output logic                 RdWritten0,
  output logic                 RdWritten1
);

  localparam int NumBytes = WIDTH / 8;
  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] DepthVal = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              wrInRange;
  logic              wrFire;
  logic [WIDTH-1:0]  wrMerged;

  assign wrInRange = ({1'b0, WrAddr} < DepthVal);
  assign wrFire    = WrEn && wrInRange && !Clr;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wrMerged = wrInRange ? mem[WrAddr] : '0;
    for (int b = 0; b < NumBytes; b++) begin
      if (WrStrb[b]) wrMerged[8*b +: 8] = WrData[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    if (!RST || Clr) begin
      // NOTE: the array is reset because its contents are architecturally visible after reset/clear.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (wrFire) begin
      mem[WrAddr]     <= wrMerged;
      written[WrAddr] <= 1'b1;
    end
  end

  logic [1:0]        rdEnV;
  logic [ADDR_W-1:0] rdAddrV [2];
  logic [WIDTH-1:0]  rdDataD [2];
  logic [1:0]        rdWrittenD;

  assign rdEnV      = {RdEn1, RdEn0};
  assign rdAddrV[0] = RdAddr0;
  assign rdAddrV[1] = RdAddr1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdDataD[p]    = '0;
      rdWrittenD[p] = 1'b0;
      if ({1'b0, rdAddrV[p]} < DepthVal) begin
        rdDataD[p]    = mem[rdAddrV[p]];
        rdWrittenD[p] = written[rdAddrV[p]];
`ifdef REG_FILE_WR_BYPASS_EN
        if (Clr) begin
          rdDataD[p]    = '0;
          rdWrittenD[p] = 1'b0;
        end else if (wrFire && (WrAddr == rdAddrV[p])) begin
          rdDataD[p]    = wrMerged;
          rdWrittenD[p] = 1'b1;
        end
`endif
      end
    end
  end

  logic [WIDTH-1:0] rdDataQ [2];
  logic [1:0]       rdValidQ;
  logic [1:0]       rdWrittenQ;

  // Data and written flag hold when a port is idle; only the valid flag follows the enable.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdDataQ[0] <= '0;
      rdDataQ[1] <= '0;
      rdValidQ   <= '0;
      rdWrittenQ <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rdValidQ[p] <= rdEnV[p];
        if (rdEnV[p]) begin
          rdDataQ[p]    <= rdDataD[p];
          rdWrittenQ[p] <= rdWrittenD[p];
        end
      end
    end
  end

  assign RdData0    = rdDataQ[0];
  assign RdData1    = rdDataQ[1];
  assign RdValid0   = rdValidQ[0];
  assign RdValid1   = rdValidQ[1];
  assign RdWritten0 = rdWrittenQ[0];
  assign RdWritten1 = rdWrittenQ[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: table-driven vectors with a scoreboard queue, plus hand sequences
// for hold, mid-read reset and a DEPTH=6 instance exercising out-of-range addresses.
module tb_reg_file_2r1w;

`ifdef REG_FILE_WR_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        Clr, WrEn, RdEn0, RdEn1;
  logic [2:0]  WrAddr, RdAddr0, RdAddr1;
  logic [1:0]  WrStrb;
  logic [15:0] WrData, RdData0, RdData1;
  logic        RdValid0, RdValid1, RdWritten0, RdWritten1;

  logic        sClr, sWrEn, sRdEn0, sRdEn1;
  logic [2:0]  sWrAddr, sRdAddr0, sRdAddr1;
  logic [1:0]  sWrStrb;
  logic [15:0] sWrData, sRdData0, sRdData1;
  logic        sRdValid0, sRdValid1, sRdWritten0, sRdWritten1;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .Clr(Clr), .WrEn(WrEn), .WrAddr(WrAddr), .WrStrb(WrStrb),
    .WrData(WrData), .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdEn1(RdEn1), .RdAddr1(RdAddr1),
    .RdData0(RdData0), .RdData1(RdData1), .RdValid0(RdValid0), .RdValid1(RdValid1),
    .RdWritten0(RdWritten0), .RdWritten1(RdWritten1)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6)) dut6 (
    .CLK(CLK), .RST(RST), .Clr(sClr), .WrEn(sWrEn), .WrAddr(sWrAddr), .WrStrb(sWrStrb),
    .WrData(sWrData), .RdEn0(sRdEn0), .RdAddr0(sRdAddr0), .RdEn1(sRdEn1), .RdAddr1(sRdAddr1),
    .RdData0(sRdData0), .RdData1(sRdData1), .RdValid0(sRdValid0), .RdValid1(sRdValid1),
    .RdWritten0(sRdWritten0), .RdWritten1(sRdWritten1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        clr;
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [1:0]  wrStrb;
    logic [15:0] wrData;
    logic        rdEn0;
    logic [2:0]  rdAddr0;
    logic        rdEn1;
    logic [2:0]  rdAddr1;
    logic [15:0] expData0;
    logic        expWr0;
    logic [15:0] expData1;
    logic        expWr1;
  } vec_t;

  typedef struct {
    string       name;
    logic        v0;
    logic [15:0] d0;
    logic        w0;
    logic        v1;
    logic [15:0] d1;
    logic        w1;
  } exp_t;

  exp_t sb[$];

  task automatic applyVec(input vec_t v, input string name);
    exp_t e;
    Clr = v.clr; WrEn = v.wrEn; WrAddr = v.wrAddr; WrStrb = v.wrStrb; WrData = v.wrData;
    RdEn0 = v.rdEn0; RdAddr0 = v.rdAddr0; RdEn1 = v.rdEn1; RdAddr1 = v.rdAddr1;
    e = '{name, v.rdEn0, v.expData0, v.expWr0, v.rdEn1, v.expData1, v.expWr1};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.name, ".valid0"}, {31'b0, RdValid0}, {31'b0, e.v0});
    check({e.name, ".valid1"}, {31'b0, RdValid1}, {31'b0, e.v1});
    if (e.v0) begin
      check({e.name, ".data0"}, {16'b0, RdData0}, {16'b0, e.d0});
      check({e.name, ".written0"}, {31'b0, RdWritten0}, {31'b0, e.w0});
    end
    if (e.v1) begin
      check({e.name, ".data1"}, {16'b0, RdData1}, {16'b0, e.d1});
      check({e.name, ".written1"}, {31'b0, RdWritten1}, {31'b0, e.w1});
    end
  endtask

  task automatic write6(input logic [2:0] a, input logic [15:0] d);
    sWrEn = 1'b1; sWrAddr = a; sWrStrb = 2'b11; sWrData = d;
    @(posedge CLK);
    #1;
    sWrEn = 1'b0;
  endtask

  task automatic read6(input string name, input logic [2:0] a0, input logic [2:0] a1,
                       input logic [15:0] d0, input logic w0, input logic [15:0] d1, input logic w1);
    sRdEn0 = 1'b1; sRdAddr0 = a0; sRdEn1 = 1'b1; sRdAddr1 = a1;
    @(posedge CLK);
    #1;
    sRdEn0 = 1'b0; sRdEn1 = 1'b0;
    check({name, ".valid0"}, {31'b0, sRdValid0}, 32'd1);
    check({name, ".data0"}, {16'b0, sRdData0}, {16'b0, d0});
    check({name, ".written0"}, {31'b0, sRdWritten0}, {31'b0, w0});
    check({name, ".valid1"}, {31'b0, sRdValid1}, 32'd1);
    check({name, ".data1"}, {16'b0, sRdData1}, {16'b0, d1});
    check({name, ".written1"}, {31'b0, sRdWritten1}, {31'b0, w1});
  endtask

  vec_t vecs[13];
  vec_t idle;

  initial begin
    // clr wrEn wA strb wData rdEn0 rA0 rdEn1 rA1 expD0 expW0 expD1 expW1
    vecs[0]  = '{0, 1, 3'd1, 2'b11, 16'h0003, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    vecs[1]  = '{0, 1, 3'd6, 2'b11, 16'h0033, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    vecs[2]  = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd1, 1, 3'd6, 16'h0003, 1, 16'h0033, 1};
    vecs[3]  = '{0, 1, 3'd3, 2'b11, 16'hABCD, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    vecs[4]  = '{0, 1, 3'd3, 2'b01, 16'h1234, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    vecs[5]  = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd3, 1, 3'd4, 16'hAB34, 1, 16'h0000, 0};
    vecs[6]  = '{0, 1, 3'd2, 2'b11, 16'h5555, 1, 3'd2, 1, 3'd2,
                 Byp ? 16'h5555 : 16'h0000, Byp, Byp ? 16'h5555 : 16'h0000, Byp};
    vecs[7]  = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd2, 1, 3'd1, 16'h5555, 1, 16'h0003, 1};
    vecs[8]  = '{0, 1, 3'd0, 2'b00, 16'hFFFF, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    vecs[9]  = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd0, 1, 3'd6, 16'h0000, 1, 16'h0033, 1};
    vecs[10] = '{1, 1, 3'd5, 2'b11, 16'hFFFF, 1, 3'd1, 1, 3'd5,
                 Byp ? 16'h0000 : 16'h0003, !Byp, 16'h0000, 0};
    vecs[11] = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd1, 1, 3'd6, 16'h0000, 0, 16'h0000, 0};
    vecs[12] = '{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd5, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};
    idle     = '{0, 0, 3'd0, 2'b00, 16'h0000, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 16'h0000, 0};

    // Reset with every other input active: all of it must be ignored.
    RST = 1'b0;
    Clr = 1'b0; WrEn = 1'b1; WrAddr = 3'd1; WrStrb = 2'b11; WrData = 16'hDEAD;
    RdEn0 = 1'b1; RdAddr0 = 3'd1; RdEn1 = 1'b1; RdAddr1 = 3'd2;
    sClr = 1'b0; sWrEn = 1'b0; sWrAddr = 3'd0; sWrStrb = 2'b00; sWrData = 16'h0000;
    sRdEn0 = 1'b0; sRdAddr0 = 3'd0; sRdEn1 = 1'b0; sRdAddr1 = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.data0", {16'b0, RdData0}, 32'h0);
    check("reset.data1", {16'b0, RdData1}, 32'h0);
    check("reset.valid", {30'b0, RdValid1, RdValid0}, 32'h0);
    check("reset.written", {30'b0, RdWritten1, RdWritten0}, 32'h0);
    RST = 1'b1;
    applyVec(idle, "post_reset");
    applyVec('{0, 0, 3'd0, 2'b00, 16'h0, 1, 3'd1, 0, 3'd0, 16'h0000, 0, 16'h0, 0}, "reset_ignored_wr");

    for (int i = 0; i < 13; i++) applyVec(vecs[i], $sformatf("vec%0d", i));

    // Idle port holds data and written flag, valid drops.
    applyVec('{0, 1, 3'd7, 2'b11, 16'h7777, 0, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0}, "hold_wr");
    applyVec('{0, 0, 3'd0, 2'b00, 16'h0000, 0, 3'd0, 1, 3'd7, 16'h0, 0, 16'h7777, 1}, "hold_rd");
    applyVec(idle, "hold_idle");
    check("hold.data1", {16'b0, RdData1}, 32'h7777);
    check("hold.written1", {31'b0, RdWritten1}, 32'h1);

    // Reset during an active read: outputs clear and no valid pulse.
    applyVec('{0, 1, 3'd1, 2'b11, 16'h0003, 0, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0}, "midrst_wr");
    applyVec('{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd1, 0, 3'd0, 16'h0003, 1, 16'h0, 0}, "midrst_pre");
    RST = 1'b0; RdEn0 = 1'b1; RdAddr0 = 3'd1;
    @(posedge CLK);
    #1;
    check("midrst.data0", {16'b0, RdData0}, 32'h0);
    check("midrst.valid0", {31'b0, RdValid0}, 32'h0);
    check("midrst.written0", {31'b0, RdWritten0}, 32'h0);
    RST = 1'b1;
    applyVec('{0, 0, 3'd0, 2'b00, 16'h0000, 1, 3'd1, 0, 3'd0, 16'h0000, 0, 16'h0, 0}, "midrst_post");

    // DEPTH=6 instance: out-of-range writes are dropped, out-of-range reads return zero.
    for (int i = 0; i < 6; i++) write6(3'(i), 16'h1110 + 16'(i));
    write6(3'd7, 16'h9999);
    write6(3'd6, 16'h9999);
    read6("oor_rd", 3'd7, 3'd6, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++)
      read6($sformatf("d6_e%0d", i), 3'(i), 3'(5 - i), 16'h1110 + 16'(i), 1'b1, 16'h1110 + 16'(5 - i), 1'b1);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with one write port and two independent read ports.
- Successor to the 8x16 single-port register file: width and depth are configurable, writes take a byte-strobe, reads are registered with a valid flag, each entry carries a "written" flag, and a bulk synchronous clear is provided.
- Serves as general scratch/config storage for datapath blocks that need two operands read per cycle.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; any value >= 2, need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-low.
- Clr  input  1  synchronous bulk clear of all entries and written flags.
- WrEn  input  1  write enable.
- WrAddr  input  ADDR_W  write address.
- WrStrb  input  WIDTH/8  byte write strobes; bit i enables WrData[8i+7:8i].
- WrData  input  WIDTH  write data.
- RdEn0 / RdEn1  input  1  read enable, port 0 / port 1.
- RdAddr0 / RdAddr1  input  ADDR_W  read address, port 0 / port 1.
- RdData0 / RdData1  output  WIDTH  registered read data.
- RdValid0 / RdValid1  output  1  one-cycle pulse; RdData is valid that cycle.
- RdWritten0 / RdWritten1  output  1  addressed entry has been written since the last reset/clear; registered alongside RdData.

Behaviour:
- Reset: at a rising CLK edge with RST=0:
  - all entries and written flags become 0;
  - RdData0/1=0, RdValid0/1=0, RdWritten0/1=0;
  - all other inputs are ignored that cycle.
- Priority at each edge: RST (low) > Clr > WrEn.
- Clr=1: all entries and written flags become 0 and any WrEn that cycle is dropped. Reads sampled in the same cycle still complete with pre-clear data unless WR_BYPASS_EN is defined (see below).
- Write: WrEn=1 and WrAddr<DEPTH updates only the bytes with WrStrb=1; other bytes are unchanged. The entry's written flag is set even when WrStrb=0.
- Out-of-range write (WrAddr>=DEPTH): ignored; no state change.
- Read, each port independent:
  - RdEn sampled at edge k; RdData, RdWritten and RdValid=1 appear after edge k (latency 1).
  - RdValid drops after the next edge if RdEn=0.
  - With RdEn=0, RdData and RdWritten hold their previous values.
- Out-of-range read: RdData=0, RdWritten=0, RdValid=1.
- Both ports reading the same address: identical results; no conflict.
- Read and write to the same address in the same cycle, without the macro: the read returns the old contents; the write still takes effect.
- Reset asserted mid-read: the output registers clear at that edge and no RdValid pulse is produced for the read.
- No back-pressure; every enabled read completes in one cycle.

Optional Feature:
- Macro: REG_FILE_WR_BYPASS_EN.
- Defined:
  - A same-cycle read of the address being written returns the merged value: new bytes where WrStrb=1, old bytes elsewhere. RdWritten=1.
  - A same-cycle read during Clr returns 0 with RdWritten=0.
  - Combinational bypass path; latency stays 1 cycle.
- Undefined: no bypass logic; old-data (read-before-write) semantics as stated in Behaviour.

Test Plan:
1. Reset, then write 0x0003 to addr 1 and 0x0033 to addr 6 (WrStrb=2'b11); read port0 addr1 and port1 addr6 in the same cycle -> one cycle later RdData0=0x0003, RdData1=0x0033, both RdValid=1, both RdWritten=1.
2. Write addr 3 = 0xABCD, then write addr 3 data 0x1234 with WrStrb=2'b01; read addr 3 -> 0xAB34. Read never-written addr 4 -> 0x0000 with RdWritten=0.
3. Same-cycle write addr 2 = 0x5555 and read addr 2 on port0 (prior value 0x0000) -> RdData0=0x0000 without the macro, 0x5555 with REG_FILE_WR_BYPASS_EN; a read the following cycle returns 0x5555 in both builds.
4. Assert Clr and WrEn (addr 5 = 0xFFFF) in the same cycle after populating entries 1 and 6 -> subsequent reads of addr 1, 5 and 6 all return 0x0000 with RdWritten=0.
5. Set RST=0 while RdEn0=1 on addr 1 (holding 0x0003) -> after that edge RdData0=0, RdValid0=0; after release, a read of addr 1 returns 0x0000.
6. DEPTH=6 build: write addr 7 = 0x9999, then read addr 7 -> RdData=0, RdValid=1, RdWritten=0; entries 0-5 unchanged.
